if_burst_sched: RTL
===================

# if_burst_sched

Burst scheduler for the off-chip interface port shared by the global buffers (config, weight/activation flags and data reads, OFM flag/data writes). It accepts level requests from up to 8 GBF requesters. It grants one at a time, with the config requester at strict top priority and the rest under round-robin or fixed priority. It drives the command handshake and counts data beats until the burst completes, holding the grant for the whole burst.

## Interface
- NUM_REQ, 7, number of requesters (2..8); index 0 is the config requester.
- BURST_LEN, 16, data beats per granted burst (2..2**CNT_WIDTH).
- CNT_WIDTH, 8, beat counter width.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Reset  in  1  synchronous clear; returns the block to IDLE.
- Req  in  NUM_REQ  level request per requester.
- RdWr_Map  in  NUM_REQ  static direction per requester: 1 = read, 0 = write.
- IF_Ack  in  1  interface accepts the command (sampled in CMD).
- IF_Beat  in  1  one data beat transferred (sampled in DATA).
- IF_Req  out  1  command request level.
- IF_RdWr  out  1  direction of the granted requester.
- IF_Sel  out  3  index of the granted requester.
- Grant  out  NUM_REQ  one-hot grant; all zero when idle.
- Beat_Cnt  out  CNT_WIDTH  beats completed in the current burst.
- Done  out  1  one-cycle pulse at burst end.

## Operation
- States: IDLE, CMD, DATA, DONE. Reset state is IDLE.
- **IDLE**
  - If any Req bit is set, select a winner combinationally.
  - Register Grant, IF_Sel and IF_RdWr = RdWr_Map[winner], then go to CMD.
  - Otherwise stay in IDLE.
- **Selection**
  - Req[0] set: index 0 wins unconditionally.
  - Otherwise the winner is chosen among indices 1..NUM_REQ-1 per Configuration.
- **CMD**
  - IF_Req = 1.
  - IF_Ack = 1: go to DATA.
  - IF_Ack = 0: hold CMD; no timeout.
- **DATA**
  - IF_Req = 0.
  - Each cycle with IF_Beat = 1 increments Beat_Cnt.
  - IF_Beat = 1 with Beat_Cnt == BURST_LEN-1: go to DONE; Beat_Cnt wraps to 0.
- **DONE**
  - Done = 1 for one cycle; go to IDLE.
  - Grant is cleared to 0 and IF_Sel to 0 on leaving DONE.
  - The round-robin pointer is updated to IF_Sel, only if IF_Sel != 0.
- **Ignored inputs**
  - Req changes after selection are ignored until IDLE; a dropped Req still completes its burst.
  - IF_Ack outside CMD is ignored; IF_Beat outside DATA is ignored.
- **Reset and rst_n**
  - Reset = 1 in any state: next state IDLE, all outputs at reset values, no Done pulse.
  - Reset does not alter the round-robin pointer.
  - rst_n clears everything, including the pointer.
- **Reset values**
  - IF_Req, IF_RdWr, Done: 0.
  - IF_Sel, Grant, Beat_Cnt: 0.
  - Round-robin pointer: NUM_REQ-1, so the first search starts at index 1.

## Timing
- Req rising in IDLE at cycle t: Grant, IF_Sel and IF_Req are valid at t+1.
- IF_Ack sampled at cycle c: IF_Req = 0 and state DATA at c+1.
- Final beat sampled at cycle b: Done = 1 at b+1; Grant = 0 at b+2.
- Back-to-back bursts: with Req pending, the next CMD starts at b+3.
- Minimum burst duration (IDLE exit to IDLE): BURST_LEN + 3 cycles.
- IF_Beat and IF_Ack in the same DATA cycle: the beat counts, the ack is ignored.

## Configuration
- Macro: IFSCHED_RR_EN.
- **Defined:** round-robin among 1..NUM_REQ-1.
  - Search starts at pointer+1, wraps from NUM_REQ-1 to 1, and skips index 0.
  - The first set Req bit found wins.
- **Undefined:** fixed priority, lowest set index among 1..NUM_REQ-1 wins.
  - The pointer register is not implemented.
- Index 0 is strict top priority in both builds.

## Test plan
- **Reset values:** rst_n low, then high; no Req, IF_Ack and IF_Beat toggling -> IF_Req = 0, Grant = 0, Done never pulses.
- **Single read burst:** Req = 7'b0000100, RdWr_Map[2] = 1, IF_Ack on the 3rd CMD cycle, 16 consecutive beats ->
  - IF_Sel = 2, Grant = 7'b0000100, IF_RdWr = 1.
  - IF_Req high for exactly 3 cycles.
  - Beat_Cnt counts 0..15, then Done pulses once.
- **Config priority:** Req = 7'b1111111 held for 3 bursts -> IF_Sel = 0 for all three. Then Req = 7'b1111110 (IFSCHED_RR_EN defined) -> IF_Sel sequence 1, 2, 3, 4, 5, 6, 1.
- **Fixed-priority build:** IFSCHED_RR_EN undefined, Req = 7'b1101000 held -> IF_Sel = 3 on every burst.
- **Ignored and gapped inputs:** during a write burst for index 5, drop Req[5] mid-DATA, insert 4-cycle beat gaps, and pulse IF_Ack in DATA -> burst completes after exactly 16 beats, Done pulses once, IF_RdWr stays 0.
- **Reset mid-burst:** Reset pulsed at Beat_Cnt = 9 -> next cycle IDLE, Beat_Cnt = 0, Grant = 0, no Done. The next round-robin winner follows the pointer value from before the Reset.

Source files
------------

// File: rtl/if_burst_sched.sv
// rtl/if_burst_sched.sv - burst scheduler for the shared off-chip interface port
// Optional feature macro: IFSCHED_RR_EN (round-robin among requesters 1..NUM_REQ-1;
// fixed lowest-index priority among 1..NUM_REQ-1 when undefined).
module if_burst_sched #(
  parameter int NUM_REQ   = 7,
  parameter int BURST_LEN = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [NUM_REQ-1:0]   RdWr_Map,
  input  logic                 IF_Ack,
  input  logic                 IF_Beat,
  output logic                 IF_Req,
  output logic                 IF_RdWr,
  output logic [2:0]           IF_Sel,
  output logic [NUM_REQ-1:0]   Grant,
  output logic [CNT_WIDTH-1:0] Beat_Cnt,
  output logic                 Done
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [2:0]             sel_q, sel_d;
  logic                   rdwr_q, rdwr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2:0]             win;

`ifdef IFSCHED_RR_EN
  logic [2:0]             ptr_q, ptr_d;
  int                     rr_idx;
  logic                   rr_found;
`endif

  // Winner selection: index 0 always first, then round-robin or fixed priority
  always_comb begin
    win = 3'd0;
`ifdef IFSCHED_RR_EN
    rr_idx   = 0;
    rr_found = 1'b0;
`endif
    if (!Req[0]) begin
`ifdef IFSCHED_RR_EN
      // Pointer always holds 1..NUM_REQ-1, so the search window is ptr+1 .. ptr+NUM_REQ-1
      // folded back into 1..NUM_REQ-1; index 0 is never visited here.
      for (int k = 1; k < NUM_REQ; k++) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx > NUM_REQ - 1) begin
          rr_idx = rr_idx - (NUM_REQ - 1);
        end
        if (!rr_found && Req[rr_idx]) begin
          win      = 3'(rr_idx);
          rr_found = 1'b1;
        end
      end
`else
      for (int k = NUM_REQ - 1; k >= 1; k--) begin
        if (Req[k]) begin
          win = 3'(k);
        end
      end
`endif
    end
  end

  // Next-state logic for the burst FSM and its registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    rdwr_d  = rdwr_q;
    cnt_d   = cnt_q;
`ifdef IFSCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          state_d = ST_CMD;
          sel_d   = win;
          grant_d = NUM_REQ'(1) << win;
          rdwr_d  = RdWr_Map[win];
        end
      end
      ST_CMD: begin
        if (IF_Ack) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (IF_Beat) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        sel_d   = 3'd0;
        rdwr_d  = 1'b0;
`ifdef IFSCHED_RR_EN
        // Config bursts do not disturb the rotation among the other requesters
        if (sel_q != 3'd0) begin
          ptr_d = sel_q;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Synchronous clear abandons the burst but keeps the rotation position
    if (Reset) begin
      state_d = ST_IDLE;
      grant_d = '0;
      sel_d   = 3'd0;
      rdwr_d  = 1'b0;
      cnt_d   = '0;
`ifdef IFSCHED_RR_EN
      ptr_d   = ptr_q;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= 3'd0;
      rdwr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      rdwr_q  <= rdwr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef IFSCHED_RR_EN
  // Round-robin pointer; starts at the top index so the first search begins at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign IF_Req   = (state_q == ST_CMD);
  assign Done     = (state_q == ST_DONE);
  assign IF_RdWr  = rdwr_q;
  assign IF_Sel   = sel_q;
  assign Grant    = grant_q;
  assign Beat_Cnt = cnt_q;

endmodule
